// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
//   Round-robin arbiter that shares one register-file write port among NREQ
//   requesters (execute / load / CSR writers). The winner's address and data
//   are registered onto the write port along with a one-hot grant. The word is
//   held while the port stalls.
//
//   State table:
//     state   | meaning
//     S_IDLE  | no word on the write port, o_gnt == 0
//     S_ISSUE | word on the write port, o_gnt one-hot names its owner
//
//   Ports:
//     i_clk, i_rst   clock (rising edge); asynchronous active-high reset
//     i_req          per-requester write request, held until its o_done cycle
//     i_addr/i_data  packed per-requester address/data, requester k at slot k
//     i_busy         write-port stall; nothing completes while high
//     o_gnt          registered one-hot owner of the current output word
//     o_done         combinational: owner whose transfer completes this cycle
//     o_we           registered write enable (0 for dropped address-0 writes)
//     o_waddr/o_wdata registered write address/data
module rf_write_arbiter #(
   parameter int NREQ      = 4,
   parameter int AW        = 5,
   parameter int DW        = 32,
   parameter int ZERO_DROP = 1
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic [NREQ-1:0]   i_req,
   input  logic [NREQ*AW-1:0] i_addr,
   input  logic [NREQ*DW-1:0] i_data,
   input  logic              i_busy,
   output logic [NREQ-1:0]   o_gnt,
   output logic [NREQ-1:0]   o_done,
   output logic              o_we,
   output logic [AW-1:0]     o_waddr,
   output logic [DW-1:0]     o_wdata
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_ISSUE = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            we_q, we_d;
   logic [AW-1:0]   waddr_q, waddr_d;
   logic [DW-1:0]   wdata_q, wdata_d;

   logic [NREQ-1:0] done;
   logic [NREQ-1:0] elig;
   logic [PW-1:0]   owner;
   logic [PW-1:0]   owner_inc;
   logic [PW-1:0]   search_ptr;
   logic [PW-1:0]   win;
   logic            win_vld;
   logic [AW-1:0]   sel_addr;
   logic [DW-1:0]   sel_data;

   // The completing owner is masked so a requester that keeps i_req high
   // cannot be re-granted on the same edge that retires its word.
   assign done = gnt_q & {NREQ{~i_busy}};
   assign elig = i_req & ~done;

   always_comb begin
      owner = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (gnt_q[k]) owner = PW'(k);
      end
   end

   assign owner_inc = (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);

   // A back-to-back issue searches from the pointer that is being written on
   // this same edge, not from the stale ptr_q.
   assign search_ptr = (state_q == S_ISSUE) ? owner_inc : ptr_q;

   always_comb begin
      logic [PW-1:0] cand;
      win_vld = 1'b0;
      win     = '0;
      cand    = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = PW'((int'(search_ptr) + i) % NREQ);
         if (!win_vld && elig[cand]) begin
            win_vld = 1'b1;
            win     = cand;
         end
      end
   end

   always_comb begin
      sel_addr = '0;
      sel_data = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (win == PW'(k)) begin
            sel_addr = i_addr[k*AW +: AW];
            sel_data = i_data[k*DW +: DW];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      gnt_d   = gnt_q;
      we_d    = we_q;
      waddr_d = waddr_q;
      wdata_d = wdata_q;

      case (state_q)
         S_IDLE: begin
            if (win_vld) begin
               state_d    = S_ISSUE;
               gnt_d      = '0;
               gnt_d[win] = 1'b1;
               we_d       = !((ZERO_DROP != 0) && (sel_addr == '0));
               waddr_d    = sel_addr;
               wdata_d    = sel_data;
            end
         end
         S_ISSUE: begin
            if (!i_busy) begin
               ptr_d = owner_inc;
               if (win_vld) begin
                  gnt_d      = '0;
                  gnt_d[win] = 1'b1;
                  we_d       = !((ZERO_DROP != 0) && (sel_addr == '0));
                  waddr_d    = sel_addr;
                  wdata_d    = sel_data;
               end else begin
                  state_d = S_IDLE;
                  gnt_d   = '0;
                  we_d    = 1'b0;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         gnt_q   <= '0;
         we_q    <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         gnt_q   <= gnt_d;
         we_q    <= we_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
      end
   end

   assign o_gnt   = gnt_q;
   assign o_done  = done;
   assign o_we    = we_q;
   assign o_waddr = waddr_q;
   assign o_wdata = wdata_q;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter
//   Directed vector table, hand-written reset and masking sequences, then
//   randomized traffic against a behavioural reference model.
module tb_rf_write_arbiter;

   localparam int NREQ = 4;
   localparam int AW   = 5;
   localparam int DW   = 32;

   logic              i_clk = 1'b0;
   logic              i_rst = 1'b1;
   logic [NREQ-1:0]   i_req = '0;
   logic [NREQ*AW-1:0] i_addr = '0;
   logic [NREQ*DW-1:0] i_data = '0;
   logic              i_busy = 1'b0;
   logic [NREQ-1:0]   o_gnt;
   logic [NREQ-1:0]   o_done;
   logic              o_we;
   logic [AW-1:0]     o_waddr;
   logic [DW-1:0]     o_wdata;

   rf_write_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .ZERO_DROP(1)) dut (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_req  (i_req),
      .i_addr (i_addr),
      .i_data (i_data),
      .i_busy (i_busy),
      .o_gnt  (o_gnt),
      .o_done (o_done),
      .o_we   (o_we),
      .o_waddr(o_waddr),
      .o_wdata(o_wdata)
   );

   always #5 i_clk = ~i_clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Fixed per-requester words used by the directed parts.
   logic [AW-1:0] c_addr [NREQ];
   logic [DW-1:0] c_data [NREQ];

   typedef struct {
      logic [NREQ-1:0] req;
      logic            busy;
      logic [NREQ-1:0] exp_done;   // during the cycle, before the edge
      logic [NREQ-1:0] exp_gnt;    // after the edge
      logic            exp_we;
      logic [AW-1:0]   exp_waddr;
   } vec_t;

   vec_t vt [13];

   function automatic int idx_of(input logic [NREQ-1:0] oh);
      int r;
      r = 0;
      for (int k = 0; k < NREQ; k++) if (oh[k]) r = k;
      return r;
   endfunction

   // Reference model: owner index (-1 = nothing on the port) and rotating pointer.
   int            m_owner;
   int            m_ptr;
   logic          m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;

   task automatic model_reset();
      m_owner = -1;
      m_ptr   = 0;
      m_we    = 1'b0;
      m_addr  = '0;
      m_data  = '0;
   endtask

   function automatic logic [NREQ-1:0] model_done(input logic b);
      if (m_owner >= 0 && !b) return NREQ'(1 << m_owner);
      return '0;
   endfunction

   function automatic logic [NREQ-1:0] model_gnt();
      if (m_owner >= 0) return NREQ'(1 << m_owner);
      return '0;
   endfunction

   task automatic model_edge(input logic [NREQ-1:0] rq, input logic b,
                             input logic [NREQ*AW-1:0] a, input logic [NREQ*DW-1:0] d);
      logic [NREQ-1:0] e;
      int k;
      e = rq & ~model_done(b);
      if (m_owner >= 0 && b) return;
      if (m_owner >= 0) begin
         m_ptr   = (m_owner + 1) % NREQ;
         m_owner = -1;
         m_we    = 1'b0;
      end
      for (int i = 0; i < NREQ; i++) begin
         k = (m_ptr + i) % NREQ;
         if (m_owner < 0 && e[k]) begin
            m_owner = k;
            m_addr  = a[k*AW +: AW];
            m_data  = d[k*DW +: DW];
            m_we    = (m_addr != '0);
         end
      end
   endtask

   logic [NREQ-1:0] pend;
   logic [NREQ-1:0] prev_done;
   logic [NREQ-1:0] exp_d;
   logic [AW-1:0]   ra [NREQ];
   logic [DW-1:0]   rd [NREQ];
   int              wait_cnt [NREQ];

   initial begin
      c_addr[0] = 5'd5;  c_data[0] = 32'hA000_0000;
      c_addr[1] = 5'd7;  c_data[1] = 32'hDEAD_BEEF;
      c_addr[2] = 5'd0;  c_data[2] = 32'hA000_0002;
      c_addr[3] = 5'd9;  c_data[3] = 32'hA000_0003;

      //           req      busy  done     gnt      we    waddr
      vt[0]  = '{4'b0010, 1'b0, 4'b0000, 4'b0010, 1'b1, 5'd7};
      vt[1]  = '{4'b0010, 1'b0, 4'b0010, 4'b0000, 1'b0, 5'd0};
      vt[2]  = '{4'b1111, 1'b0, 4'b0000, 4'b0100, 1'b0, 5'd0};
      vt[3]  = '{4'b1111, 1'b0, 4'b0100, 4'b1000, 1'b1, 5'd9};
      vt[4]  = '{4'b1111, 1'b1, 4'b0000, 4'b1000, 1'b1, 5'd9};
      vt[5]  = '{4'b1111, 1'b1, 4'b0000, 4'b1000, 1'b1, 5'd9};
      vt[6]  = '{4'b1111, 1'b1, 4'b0000, 4'b1000, 1'b1, 5'd9};
      vt[7]  = '{4'b1111, 1'b0, 4'b1000, 4'b0001, 1'b1, 5'd5};
      vt[8]  = '{4'b1111, 1'b0, 4'b0001, 4'b0010, 1'b1, 5'd7};
      vt[9]  = '{4'b1111, 1'b0, 4'b0010, 4'b0100, 1'b0, 5'd0};
      vt[10] = '{4'b1111, 1'b0, 4'b0100, 4'b1000, 1'b1, 5'd9};
      vt[11] = '{4'b1000, 1'b0, 4'b1000, 4'b0000, 1'b0, 5'd0};
      vt[12] = '{4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 5'd0};

      for (int k = 0; k < NREQ; k++) begin
         i_addr[k*AW +: AW] = c_addr[k];
         i_data[k*DW +: DW] = c_data[k];
      end

      // Reset values
      #2;
      chk("rst_gnt",   o_gnt,   0);
      chk("rst_we",    o_we,    0);
      chk("rst_waddr", o_waddr, 0);
      chk("rst_wdata", o_wdata, 0);
      chk("rst_done",  o_done,  0);
      @(negedge i_clk);
      i_rst = 1'b0;

      // Directed vector table
      for (int r = 0; r < 13; r++) begin
         i_req  = vt[r].req;
         i_busy = vt[r].busy;
         #1;
         chk($sformatf("vec%0d_done", r), o_done, vt[r].exp_done);
         @(posedge i_clk);
         #1;
         chk($sformatf("vec%0d_gnt", r), o_gnt, vt[r].exp_gnt);
         chk($sformatf("vec%0d_we", r),  o_we,  vt[r].exp_we);
         if (vt[r].exp_gnt != '0) begin
            chk($sformatf("vec%0d_waddr", r), o_waddr, vt[r].exp_waddr);
            chk($sformatf("vec%0d_wdata", r), o_wdata, c_data[idx_of(vt[r].exp_gnt)]);
         end
      end

      // Masking: requester 0 alone, always requesting, writes every other cycle
      for (int i = 0; i < 8; i++) begin
         i_req  = 4'b0001;
         i_busy = 1'b0;
         #1;
         chk($sformatf("mask%0d_done", i), o_done, (i % 2 == 1) ? 4'b0001 : 4'b0000);
         @(posedge i_clk);
         #1;
         chk($sformatf("mask%0d_we", i),  o_we,  (i % 2 == 0) ? 1'b1 : 1'b0);
         chk($sformatf("mask%0d_gnt", i), o_gnt, (i % 2 == 0) ? 4'b0001 : 4'b0000);
      end

      // Async reset in the middle of a stalled issue
      i_req  = 4'b0001;
      i_busy = 1'b1;
      @(posedge i_clk);
      #1;
      chk("stall_gnt", o_gnt, 4'b0001);
      #2;
      i_rst = 1'b1;
      #1;
      chk("arst_gnt",   o_gnt,   0);
      chk("arst_we",    o_we,    0);
      chk("arst_waddr", o_waddr, 0);
      chk("arst_wdata", o_wdata, 0);
      chk("arst_done",  o_done,  0);
      @(negedge i_clk);
      i_rst  = 1'b0;
      i_busy = 1'b0;
      @(posedge i_clk);
      #1;
      chk("arst_regrant", o_gnt, 4'b0001);
      chk("arst_regrant_we", o_we, 1'b1);

      // Randomized traffic against the model
      i_rst = 1'b1;
      i_req = '0;
      model_reset();
      pend      = '0;
      prev_done = '0;
      for (int k = 0; k < NREQ; k++) wait_cnt[k] = 0;
      @(negedge i_clk);
      i_rst = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         for (int k = 0; k < NREQ; k++) begin
            if (prev_done[k]) begin
               chk($sformatf("starve%0d", k), (wait_cnt[k] <= NREQ), 1'b1);
               pend[k] = 1'b0;
            end
            if (!pend[k] && $urandom_range(0, 99) < 60) begin
               pend[k]     = 1'b1;
               wait_cnt[k] = 0;
               ra[k] = ($urandom_range(0, 3) == 0) ? '0 : AW'($urandom);
               rd[k] = $urandom;
            end else if (!pend[k]) begin
               ra[k] = AW'($urandom);
               rd[k] = $urandom;
            end
            i_req[k]           = pend[k];
            i_addr[k*AW +: AW] = ra[k];
            i_data[k*DW +: DW] = rd[k];
         end
         i_busy = ($urandom_range(0, 99) < 30);
         #1;
         exp_d = model_done(i_busy);
         chk("rnd_done", o_done, exp_d);
         prev_done = exp_d;
         if (exp_d != '0) begin
            for (int k = 0; k < NREQ; k++) if (pend[k]) wait_cnt[k]++;
         end
         @(posedge i_clk);
         model_edge(i_req, i_busy, i_addr, i_data);
         #1;
         chk("rnd_gnt", o_gnt, model_gnt());
         chk("rnd_we",  o_we,  m_we);
         if (m_owner >= 0) begin
            chk("rnd_waddr", o_waddr, m_addr);
            chk("rnd_wdata", o_wdata, m_data);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
